// File: rtl/fp_pkg.sv
// Shared floating-point constants, packed-float field positions and pipeline payloads.
package fp_pkg;

    localparam int unsigned MW       = 24;
    localparam int unsigned EW       = 8;
    localparam int unsigned LZW      = 5;
    localparam int unsigned FW       = 32;
    localparam int unsigned CW       = 16;
    localparam int unsigned XW       = 10;
    localparam int unsigned BIAS     = 127;
    localparam int unsigned SIGN_POS = 31;
    localparam int unsigned EXP_HI   = 30;
    localparam int unsigned EXP_LO   = 23;
    localparam int unsigned FRAC_HI  = 22;
    localparam int unsigned FRAC_LO  = 0;

    localparam logic [FW-1:0] QNAN = 32'h7FC0_0000;

    // Stage A payload: the incoming bundle plus its leading-zero count.
    typedef struct packed {
        logic [LZW-1:0] lz;
        logic [MW-1:0]  z;
        logic [EW-1:0]  ze;
        logic           zs;
        logic           e;
        logic           zero;
    } stage_a_t;

endpackage

// File: rtl/lzc24.sv
// Combinational leading-zero counter; returns MW when the input is all zero.
module lzc24
    import fp_pkg::*;
(
    input  logic [MW-1:0]  z,
    output logic [LZW-1:0] lz_c
);

    logic found;

    always_comb begin
        lz_c  = LZW'(MW);
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found && z[i]) begin
                lz_c  = LZW'(MW - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_pack_stage.sv
// Final FP multiplier stage: normalise mantissa, adjust exponent, pack IEEE-754 single.
// Two-stage valid/ready pipeline with sticky underflow / sign-error flags and a result counter.
module fp_pack_stage
    import fp_pkg::*;
(
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [MW-1:0] Z,
    input  logic [EW-1:0] ZE,
    input  logic          ZS,
    input  logic          AS,
    input  logic          BS,
    input  logic          E,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [FW-1:0] F,
    output logic          UF,
    output logic          SE,
    input  logic          CLR,
    output logic [CW-1:0] CNT
);

    stage_a_t         a_q;
    logic             a_valid;
    logic             b_valid;
    logic [LZW-1:0]   lz_c;
    logic             a_ready_c;
    logic             b_ready_c;
    logic             in_fire_c;
    logic             a_fire_c;
    logic             out_fire_c;
    logic             se_set_c;
    logic             uf_set_c;
    logic [FW-1:0]    f_next_c;
    logic signed [XW-1:0] e_c;
    logic [MW-2:0]    z_norm_c;

    lzc24 u_lzc (
        .z    (Z),
        .lz_c (lz_c)
    );

    assign b_ready_c  = !b_valid || OUT_READY;
    assign a_ready_c  = !a_valid || b_ready_c;
    assign IN_READY   = a_ready_c;
    assign in_fire_c  = IN_VALID && a_ready_c;
    assign a_fire_c   = a_valid && b_ready_c;
    assign out_fire_c = b_valid && OUT_READY;
    assign se_set_c   = in_fire_c && (ZS != (AS ^ BS));
    assign OUT_VALID  = b_valid;

    // Stage B packing: exception, zero, infinity, underflow, then normal.
    always_comb begin
        f_next_c = '0;
        uf_set_c = 1'b0;
        e_c      = $signed(XW'(a_q.ze)) - $signed(XW'(a_q.lz));
        z_norm_c = (MW-1)'(a_q.z << a_q.lz);
        if (a_q.e) begin
            f_next_c           = QNAN;
            f_next_c[SIGN_POS] = a_q.zs;
        end else if (a_q.zero) begin
            f_next_c[SIGN_POS] = a_q.zs;
        end else if (a_q.ze == '1) begin
            f_next_c[SIGN_POS]      = a_q.zs;
            f_next_c[EXP_HI:EXP_LO] = '1;
        end else if (e_c <= $signed(XW'(0))) begin
            f_next_c[SIGN_POS] = a_q.zs;
            uf_set_c           = a_fire_c;
        end else begin
            f_next_c[SIGN_POS]        = a_q.zs;
            f_next_c[EXP_HI:EXP_LO]   = e_c[EW-1:0];
            f_next_c[FRAC_HI:FRAC_LO] = z_norm_c;
        end
    end

    // Stage A register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_valid <= 1'b0;
            a_q     <= '0;
        end else begin
            if (a_ready_c) a_valid <= IN_VALID;
            if (in_fire_c) begin
                a_q.lz   <= lz_c;
                a_q.z    <= Z;
                a_q.ze   <= ZE;
                a_q.zs   <= ZS;
                a_q.e    <= E;
                a_q.zero <= (Z == '0);
            end
        end
    end

    // Stage B register; F holds while the consumer stalls.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            b_valid <= 1'b0;
            F       <= '0;
        end else begin
            if (b_ready_c) b_valid <= a_valid;
            if (a_fire_c)  F       <= f_next_c;
        end
    end

    // Sticky flags (set beats clear) and delivered-result counter (clear beats count).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            UF  <= 1'b0;
            SE  <= 1'b0;
            CNT <= '0;
        end else begin
            if (uf_set_c)  UF <= 1'b1;
            else if (CLR)  UF <= 1'b0;
            if (se_set_c)  SE <= 1'b1;
            else if (CLR)  SE <= 1'b0;
            if (CLR)             CNT <= '0;
            else if (out_fire_c) CNT <= CNT + CW'(1);
        end
    end

endmodule

// File: tb/tb_fp_pack_stage.sv
// Scoreboard bench for fp_pack_stage: directed plan cases plus randomized traffic with back-pressure.
module tb_fp_pack_stage;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [23:0] Z = '0;
    logic [7:0]  ZE = '0;
    logic        ZS = 1'b0, AS = 1'b0, BS = 1'b0, E = 1'b0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [31:0] F;
    logic        UF, SE;
    logic        CLR = 1'b0;
    logic [15:0] CNT;

    fp_pack_stage dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .Z(Z), .ZE(ZE), .ZS(ZS), .AS(AS), .BS(BS), .E(E),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .F(F),
        .UF(UF), .SE(SE), .CLR(CLR), .CNT(CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] f;
        logic        uf;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] cnt_m = '0;
    logic        uf_m = 1'b0;
    logic        se_m = 1'b0;
    logic        rand_ready = 1'b0;
    logic        holding = 1'b0;
    logic [31:0] hold_f = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: value-level IEEE packing from the rules, not the pipeline structure.
    function automatic logic [31:0] model(input logic [23:0] z, input logic [7:0] ze,
                                          input logic zs, input logic e, output logic uf);
        int msb;
        int lz;
        int ex;
        longint unsigned m;
        uf = 1'b0;
        if (e) return {zs, 8'hFF, 23'h400000};
        if (z == 0) return {zs, 31'b0};
        if (ze == 8'hFF) return {zs, 8'hFF, 23'b0};
        msb = 0;
        for (int i = 0; i < 24; i++) if (z[i]) msb = i;
        lz = 23 - msb;
        ex = int'(ze) - lz;
        if (ex <= 0) begin
            uf = 1'b1;
            return {zs, 31'b0};
        end
        m = longint'(z) * (64'd1 << lz);
        return {zs, 8'(ex), 23'(m % 64'h800000)};
    endfunction

    task automatic send(input logic [23:0] z, input logic [7:0] ze, input logic zs,
                        input logic as_i, input logic bs_i, input logic e);
        exp_t x;
        logic u;
        int   n;
        IN_VALID = 1'b1; Z = z; ZE = ze; ZS = zs; AS = as_i; BS = bs_i; E = e;
        n = 0;
        forever begin
            @(negedge CLK);
            if (IN_READY) break;
            n++;
            if (n > 200) begin
                checks++; failures++;
                $display("FAIL accept_timeout actual=stalled required=accept");
                break;
            end
        end
        if (IN_READY) begin
            x.f  = model(z, ze, zs, e, u);
            uf_m = uf_m | u;
            se_m = se_m | (zs != (as_i ^ bs_i));
            x.uf = uf_m;
            q.push_back(x);
        end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge CLK); #1;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", q.size());
        end
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic clear();
        CLR = 1'b1;
        @(posedge CLK); #1;
        CLR = 1'b0;
        uf_m = 1'b0; se_m = 1'b0; cnt_m = '0;
    endtask

    // Monitor: pops the scoreboard on each output transfer and checks stall stability.
    always @(negedge CLK) begin
        if (!RST_N) begin
            holding <= 1'b0;
        end else begin
            if (holding) begin
                chk("hold_valid", 32'(OUT_VALID), 32'd1);
                chk("hold_f", F, hold_f);
            end
            if (OUT_VALID && OUT_READY) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_output actual=%h required=none", F);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    chk("f", F, x.f);
                    chk("uf_at_output", 32'(UF), 32'(x.uf));
                    chk("cnt_before", 32'(CNT), 32'(cnt_m));
                    cnt_m = cnt_m + 16'd1;
                end
                holding <= 1'b0;
            end else if (OUT_VALID) begin
                holding <= 1'b1;
                hold_f  <= F;
            end else begin
                holding <= 1'b0;
            end
        end
    end

    always @(posedge CLK) begin
        #1;
        if (rand_ready) OUT_READY = ($urandom_range(0, 3) != 0);
    end

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_f", F, 32'd0);
        chk("rst_uf", 32'(UF), 32'd0);
        chk("rst_se", 32'(SE), 32'd0);
        chk("rst_cnt", 32'(CNT), 32'd0);
        chk("rst_in_ready", 32'(IN_READY), 32'd1);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;

        send(24'h800000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        chk("one_cnt", 32'(CNT), 32'd1);
        chk("one_uf", 32'(UF), 32'd0);
        chk("one_se", 32'(SE), 32'd0);

        send(24'h400001, 8'd130, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        send(24'h000001, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        chk("uf_set", 32'(UF), 32'd1);
        clear();
        chk("uf_clr", 32'(UF), 32'd0);
        chk("cnt_clr", 32'(CNT), 32'd0);

        send(24'h123456, 8'd90, 1'b1, 1'b0, 1'b1, 1'b1);
        send(24'hC00000, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        send(24'h000000, 8'd50, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();
        chk("se_clean", 32'(SE), 32'd0);
        send(24'hABCDEF, 8'd100, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();
        chk("se_set", 32'(SE), 32'd1);
        clear();
        chk("se_clr", 32'(SE), 32'd0);

        fork
            begin
                send(24'h800001, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
                send(24'h0F0F0F, 8'd200, 1'b1, 1'b1, 1'b0, 1'b0);
                send(24'h000100, 8'd16, 1'b0, 1'b0, 1'b0, 1'b0);
                send(24'hFFFFFF, 8'd254, 1'b1, 1'b0, 1'b1, 1'b0);
            end
            begin
                OUT_READY = 1'b0;
                repeat (3) @(posedge CLK);
                #1;
                chk("stall_in_ready", 32'(IN_READY), 32'd0);
                chk("stall_out_valid", 32'(OUT_VALID), 32'd1);
                OUT_READY = 1'b1;
            end
        join
        drain();
        chk("stall_cnt", 32'(CNT), 32'd4);
        chk("stall_cnt_model", 32'(CNT), 32'(cnt_m));

        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            logic [23:0] z;
            logic [7:0]  ze;
            z  = 24'($urandom) >> $urandom_range(0, 24);
            ze = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 60));
            if ($urandom_range(0, 1) == 1) ze = 8'($urandom);
            send(z, ze, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge CLK);
                #1;
            end
        end
        rand_ready = 1'b0;
        #1 OUT_READY = 1'b1;
        drain();
        chk("rand_cnt", 32'(CNT), 32'(cnt_m));
        chk("rand_uf", 32'(UF), 32'(uf_m));
        chk("rand_se", 32'(SE), 32'(se_m));
        clear();

        send(24'h900000, 8'd140, 1'b0, 1'b0, 1'b0, 1'b0);
        send(24'h0A0000, 8'd140, 1'b0, 1'b0, 1'b0, 1'b0);
        RST_N = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(OUT_VALID), 32'd0);
        q.delete();
        cnt_m = '0; uf_m = 1'b0; se_m = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        chk("rst_mid_cnt", 32'(CNT), 32'd0);
        chk("rst_mid_valid_after", 32'(OUT_VALID), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
